// File: rtl/buffer4x1_pack_ctrl.sv
// Packs an upstream byte stream into an external 4-entry byte buffer (buffer4x1)
// and presents each completed or flushed 32-bit word downstream.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   in_data/in_valid  upstream byte and its valid; in_ready is the accept strobe
//   flush             closes the current partial word early
//   word_ready        downstream accepts the buffered word
//   word_valid        buffer holds a complete or flushed word
//   word_bytes        valid byte count (1..4) of the held word, MSB-first
//   buf_init/write/address/data  drive the buffer's control and data inputs
//   busy              not idle: state is not FILL or a partial word is pending
//   words_done        count of completed word handshakes (wraps)
module buffer4x1_pack_ctrl #(
  parameter int unsigned BYTES = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic             word_ready,
  output logic             word_valid,
  output logic [2:0]       word_bytes,
  output logic             buf_init,
  output logic             buf_write,
  output logic [1:0]       buf_address,
  output logic [7:0]       buf_data,
  output logic             busy,
  output logic [CNT_W-1:0] words_done
);

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StFill  = 2'd1,
    StHold  = 2'd2
  } state_e;

  localparam logic [2:0] LastIdx = 3'(BYTES - 1);
  localparam logic [2:0] Full    = 3'(BYTES);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       word_bytes_q, word_bytes_d;
  logic [CNT_W-1:0] words_done_q, words_done_d;
  logic             accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StClear;
      cnt_q        <= 3'd0;
      word_bytes_q <= 3'd0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_bytes_q <= word_bytes_d;
      words_done_q <= words_done_d;
    end
  end

  // Data and address pass straight through; only buf_write qualifies them.
  assign buf_data    = in_data;
  assign buf_address = cnt_q[1:0];
  assign accept      = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_bytes_d = word_bytes_q;
    words_done_d = words_done_q;
    in_ready     = 1'b0;
    buf_init     = 1'b0;
    buf_write    = 1'b0;
    word_valid   = 1'b0;

    unique case (state_q)
      StClear: begin
        // The buffer has no reset, so every word starts by wiping it.
        buf_init = 1'b1;
        cnt_d    = 3'd0;
        state_d  = StFill;
      end
      StFill: begin
        in_ready  = 1'b1;
        buf_write = in_valid;
        if (accept) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == LastIdx) begin
            word_bytes_d = Full;
            state_d      = StHold;
          end else if (flush) begin
            // Byte lands in the same cycle as the flush, so it counts.
            word_bytes_d = cnt_q + 3'd1;
            state_d      = StHold;
          end
        end else if (flush && (cnt_q != 3'd0)) begin
          word_bytes_d = cnt_q;
          state_d      = StHold;
        end
      end
      StHold: begin
        word_valid = 1'b1;
        if (word_ready) begin
          words_done_d = words_done_q + 1'b1;
          cnt_d        = 3'd0;
          state_d      = StClear;
        end
      end
      default: begin
        state_d = StClear;
        cnt_d   = 3'd0;
      end
    endcase
  end

  assign busy       = (state_q != StFill) || (cnt_q != 3'd0);
  assign word_bytes = word_bytes_q;
  assign words_done = words_done_q;

endmodule

// File: doc/buffer4x1_pack_ctrl.md
Name: buffer4x1_pack_ctrl

Overview:
Controller that packs an upstream byte stream into the 4-entry byte buffer and presents each completed 32-bit word downstream. It sequences the buffer's init, write, address and data inputs, applies valid/ready handshakes on both sides, and supports early flush of a partial word. It sits between a byte producer and the 32-bit word consumer, wrapping one buffer4x1 instance that is external to this block.

Parameters:
BYTES, 4, bytes per word; fixed at 4 to match the buffer depth; the address is 2 bits.
CNT_W, 8, width of the completed-word counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
in_data  input  8  upstream byte
in_valid  input  1  upstream byte present
in_ready  output  1  controller can accept a byte this cycle
flush  input  1  close the current partial word early
word_ready  input  1  downstream accepts the buffered word
word_valid  output  1  buffer holds a complete or flushed word
word_bytes  output  3  number of valid bytes in the word (1..4), MSB-first
buf_init  output  1  to the buffer's init input
buf_write  output  1  to the buffer's write input
buf_address  output  2  to the buffer's address input
buf_data  output  8  to the buffer's data_in input
busy  output  1  high when the state is not FILL or the byte count is nonzero
words_done  output  CNT_W  count of completed word handshakes, wraps

Behaviour:
- States: CLEAR, FILL, HOLD. Byte counter cnt is 3 bits, range 0..4.
- On rst low (asynchronous): state=CLEAR, cnt=0, words_done=0, word_bytes=0.
  - Resulting outputs: word_valid=0, in_ready=0, buf_write=0, buf_init=1.
  - The buffer has no reset of its own, so CLEAR wipes its contents first.
- CLEAR:
  - Drive buf_init=1, buf_write=0, in_ready=0.
  - Next cycle: FILL with cnt=0.
  - Lasts exactly one cycle.
- FILL:
  - in_ready=1 and buf_init=0.
  - buf_data=in_data and buf_address=cnt[1:0] (combinational).
  - buf_write=in_valid.
  - Accept means in_valid and in_ready both high; on accept, cnt increments.
  - Accept with cnt==3: go to HOLD, word_bytes=4.
  - flush with cnt>0 and no accept: go to HOLD, word_bytes=cnt.
  - flush together with accept: the byte is written first, then go to HOLD, word_bytes=cnt+1.
  - flush with cnt==0 and no accept: ignored, stay in FILL.
- HOLD:
  - word_valid=1, in_ready=0, buf_write=0.
  - The buffer output is stable and valid, with byte 0 in bits [31:24].
  - Unwritten byte slots read 0, because the buffer was cleared in CLEAR.
  - On word_ready: words_done increments modulo 2^CNT_W, then go to CLEAR, cnt=0.
  - No word_ready: hold indefinitely. word_bytes and the buffer contents do not change.
- Latency:
  - The first byte is accepted 1 cycle after rst is released (the CLEAR cycle).
  - word_valid rises the cycle after the 4th accept.
  - Minimum period per word is 6 cycles: 4 FILL, 1 HOLD, 1 CLEAR.
- rst asserted mid-word: any partial word is discarded, and the controller returns to CLEAR.
- word_ready outside HOLD and in_valid outside FILL are both ignored.

Test Plan:
- Reset then idle:
  - Release rst, hold in_valid=0 for 5 cycles.
  - Expect buf_init=1 only in the first cycle, in_ready=1 afterwards, word_valid=0, busy=0.
- Full word:
  - Stream bytes 0x11, 0x22, 0x33, 0x44 back-to-back with word_ready=1.
  - Expect buf_address 0,1,2,3 with buf_write=1 on each.
  - Next cycle: word_valid=1, word_bytes=4, buffer output 0x11223344.
  - Then one buf_init cycle, and words_done goes to 1.
- Backpressure:
  - Same stream with word_ready=0 for 10 cycles.
  - Expect word_valid held high, in_ready=0, and an in_valid=1 of 0x55 not written.
  - Release word_ready: expect CLEAR, then 0x55 accepted at address 0.
- Flush:
  - Send 0xAA, 0xBB, then pulse flush alone.
  - Expect word_bytes=2 and buffer output 0xAABB0000.
  - Flush with cnt==0: no state change.
- Flush with accept:
  - Send 0x01, then 0x02 with flush=1 in the same cycle.
  - Expect word_bytes=2 and buffer output 0x01020000.
- Mid-word reset:
  - Send 0x7F, 0x80, then assert rst.
  - Expect word_valid=0 immediately, then buf_init on release.
  - The next full word 0xDEADBEEF reads back with no residue from the discarded bytes.
